// File: rtl/riscv_div_pkg.sv
// Shared definitions for the iterative divider and its issue controller.
//   - op codes presented on rs_op / div_op_sel
//   - controller state encoding
//   - default ROB tag width
package riscv_div_pkg;

  localparam int unsigned DIV_TAG_W = 6;

  localparam logic [4:0] OP_DIV  = 5'b10100;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } div_state_e;

endpackage

// File: rtl/div_fast_path.sv
// Combinational classifier for divide ops whose result is known without
// iterating: divide by zero, signed overflow (INT_MIN / -1) and divide by one.
// Ports:
//   op_i      op code (OP_DIV/OP_DIVU/OP_REM/OP_REMU)
//   src1_i    dividend
//   src2_i    divisor
//   hit_o     op is trivial, result_o is valid
//   result_o  architectural result of the trivial op
module div_fast_path
  import riscv_div_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        hit_o,
  output logic [31:0] result_o
);

  logic is_div;
  logic is_signed;

  assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign is_signed = (op_i == OP_DIV) || (op_i == OP_REM);

  always_comb begin
    hit_o    = 1'b0;
    result_o = '0;
    if (src2_i == '0) begin
      hit_o    = 1'b1;
      result_o = is_div ? '1 : src1_i;
    end else if (is_signed && (src1_i == 32'h8000_0000) && (src2_i == '1)) begin
      hit_o    = 1'b1;
      result_o = is_div ? 32'h8000_0000 : '0;
    end else if (src2_i == 32'd1) begin
      hit_o    = 1'b1;
      result_o = is_div ? src1_i : '0;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the iterative 32-bit divider. Accepts one
// DIV/DIVU/REM/REMU op from the reservation station, launches it on the
// divider start/done interface, and broadcasts the result on the CDB via
// request/grant. Flushes kill the held op; a running divider is drained.
// Optional feature: define DIV_FASTPATH_EN to complete trivial ops
// (x/0, INT_MIN/-1, x/1) directly from IDLE without starting the divider.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 kills the held op
//   rs_valid/rs_ready     RS handshake (rs_ready high only in IDLE)
//   rs_op, rs_src1/2,     op, dividend/divisor, ROB tag
//   rs_tag
//   div_start             one-cycle launch pulse
//   div_op_sel, div_rs1/2 registered op/operands, stable until div_done
//   div_busy              divider busy (monitored only)
//   div_done, div_result  divider completion pulse and result
//   cdb_req/cdb_grant     CDB handshake
//   cdb_tag, cdb_data     broadcast tag and result
module div_issue_ctrl
  import riscv_div_pkg::*;
#(
  parameter int unsigned TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             rs_valid,
  output logic             rs_ready,
  input  logic [4:0]       rs_op,
  input  logic [31:0]      rs_src1,
  input  logic [31:0]      rs_src2,
  input  logic [TAG_W-1:0] rs_tag,
  output logic             div_start,
  output logic [4:0]       div_op_sel,
  output logic [31:0]      div_rs1,
  output logic [31:0]      div_rs2,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [31:0]      div_result,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data
);

  div_state_e       state_q;
  logic             start_q;
  logic [4:0]       op_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic             req_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  logic             accept;
  logic             fast_hit;
  logic [31:0]      fast_result;
  logic             unused_busy;

  // Busy is informational only; completion is tracked by div_done.
  assign unused_busy = div_busy;

`ifdef DIV_FASTPATH_EN
  div_fast_path u_fast_path (
    .op_i     (rs_op),
    .src1_i   (rs_src1),
    .src2_i   (rs_src2),
    .hit_o    (fast_hit),
    .result_o (fast_result)
  );
`else
  assign fast_hit    = 1'b0;
  assign fast_result = '0;
`endif

  assign rs_ready = (state_q == ST_IDLE);
  assign accept   = rs_valid && rs_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      req_q   <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= rs_op;
            rs1_q <= rs_src1;
            rs2_q <= rs_src2;
            tag_q <= rs_tag;
            if (fast_hit) begin
              data_q  <= fast_result;
              req_q   <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              start_q <= 1'b1;
              state_q <= ST_LAUNCH;
            end
          end
        end
        // The divider has already seen start, so a flush here must drain.
        // A done pulse in this cycle cannot belong to this op and is ignored.
        ST_LAUNCH: state_q <= flush ? ST_DRAIN : ST_WAIT;
        ST_WAIT: begin
          if (div_done) begin
            if (flush) begin
              state_q <= ST_IDLE;
            end else begin
              data_q  <= div_result;
              req_q   <= 1'b1;
              state_q <= ST_HOLD;
            end
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end
        end
        // Flush and grant both leave HOLD; flush simply means nothing was sent.
        ST_HOLD: begin
          if (flush || cdb_grant) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (div_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign div_start  = start_q;
  assign div_op_sel = op_q;
  assign div_rs1    = rs1_q;
  assign div_rs2    = rs2_q;
  assign cdb_req    = req_q;
  assign cdb_tag    = tag_q;
  assign cdb_data   = data_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed vector table, multi-cycle
// flush/reset sequences, and randomized traffic against a queue-based model.
// Expected latencies follow DIV_FASTPATH_EN when it is defined.
module tb_div_issue_ctrl;
  import riscv_div_pkg::*;

  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DIV_CNT = 34;  // start seen at cycle 2 -> done in cycle 36

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             rs_valid;
  logic             rs_ready;
  logic [4:0]       rs_op;
  logic [31:0]      rs_src1;
  logic [31:0]      rs_src2;
  logic [TAG_W-1:0] rs_tag;
  logic             div_start;
  logic [4:0]       div_op_sel;
  logic [31:0]      div_rs1;
  logic [31:0]      div_rs2;
  logic             div_busy;
  logic             div_done;
  logic [31:0]      div_result;
  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned overlap = 0;
  int unsigned cnt;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .rs_valid   (rs_valid),
    .rs_ready   (rs_ready),
    .rs_op      (rs_op),
    .rs_src1    (rs_src1),
    .rs_src2    (rs_src2),
    .rs_tag     (rs_tag),
    .div_start  (div_start),
    .div_op_sel (div_op_sel),
    .div_rs1    (div_rs1),
    .div_rs2    (div_rs2),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_result (div_result),
    .cdb_req    (cdb_req),
    .cdb_grant  (cdb_grant),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // Architectural RISC-V divide semantics.
  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, r;
    logic is_rem, is_uns;
    is_rem = (op == OP_REM) || (op == OP_REMU);
    is_uns = (op == OP_DIVU) || (op == OP_REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    sa = is_uns ? longint'(a) : longint'($signed(a));
    sb = is_uns ? longint'(b) : longint'($signed(b));
    r  = is_rem ? (sa % sb) : (sa / sb);
    return r[31:0];
  endfunction

  // Divider model: fixed latency; result formed from the operand bus at the
  // done cycle, so operands must still be held then.
  assign div_busy = (cnt != 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 0;
      div_done   <= 1'b0;
      div_result <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        if (cnt != 0) overlap <= overlap + 1;
        cnt <= DIV_CNT;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          div_done   <= 1'b1;
          div_result <= ref_div(div_op_sel, div_rs1, div_rs2);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents an op in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
    check("accept_ready", 32'(rs_ready), 32'd1);
    rs_valid = 1'b1;
    rs_op    = op;
    rs_src1  = a;
    rs_src2  = b;
    rs_tag   = tag;
    @(negedge clk);
    rs_valid = 1'b0;
  endtask

  // From cycle 1, waits for cdb_req; rs_ready must stay low meanwhile.
  task automatic wait_req(output int unsigned lat, output bit seen);
    lat  = 1;
    seen = 1'b0;
    while (lat < 100) begin
      check("ready_low_busy", 32'(rs_ready), 32'd0);
      if (cdb_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("req_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp,
                        input bit trivial, input int unsigned gdly);
    int unsigned lat, exp_lat;
    bit seen;
    exp_lat = 37;
`ifdef DIV_FASTPATH_EN
    if (trivial) exp_lat = 1;
`endif
    start_op(op, a, b, tag);
    check("div_start", 32'(div_start), (exp_lat == 1) ? 32'd0 : 32'd1);
    wait_req(lat, seen);
    if (!seen) return;
    check("latency", lat, exp_lat);
    check("cdb_tag", 32'(cdb_tag), 32'(tag));
    check("cdb_data", cdb_data, exp);
    for (int unsigned k = 0; k < gdly; k++) begin
      @(negedge clk);
      check("hold_req", 32'(cdb_req), 32'd1);
      check("hold_tag", 32'(cdb_tag), 32'(tag));
      check("hold_data", cdb_data, exp);
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
    check("req_after_grant", 32'(cdb_req), 32'd0);
    check("ready_after_grant", 32'(rs_ready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag_s);
    check({tag_s, "_div_start"}, 32'(div_start), 32'd0);
    check({tag_s, "_op_sel"}, 32'(div_op_sel), 32'd0);
    check({tag_s, "_rs1"}, div_rs1, 32'd0);
    check({tag_s, "_rs2"}, div_rs2, 32'd0);
    check({tag_s, "_cdb_req"}, 32'(cdb_req), 32'd0);
    check({tag_s, "_cdb_tag"}, 32'(cdb_tag), 32'd0);
    check({tag_s, "_cdb_data"}, cdb_data, 32'd0);
  endtask

  typedef struct {
    logic [4:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    bit               trivial;
    int unsigned      gdly;
  } vec_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  vec_t vecs[13];

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'($urandom_range(0, 50));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(2, 17));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    exp_t        q[$];
    exp_t        e;
    int unsigned age;
    int unsigned lat;
    int unsigned n_bcast;
    bit          seen;

    vecs[0]  = '{op: OP_DIV,  a: 32'hFFFF_FFF9, b: 32'd2,         tag: 6'd5,  exp: 32'hFFFF_FFFD, trivial: 1'b0, gdly: 0};
    vecs[1]  = '{op: OP_REMU, a: 32'd100,       b: 32'd7,         tag: 6'd12, exp: 32'd2,         trivial: 1'b0, gdly: 10};
    vecs[2]  = '{op: OP_DIV,  a: 32'd5,         b: 32'd0,         tag: 6'd7,  exp: 32'hFFFF_FFFF, trivial: 1'b1, gdly: 0};
    vecs[3]  = '{op: OP_REM,  a: 32'd5,         b: 32'd0,         tag: 6'd8,  exp: 32'd5,         trivial: 1'b1, gdly: 2};
    vecs[4]  = '{op: OP_DIV,  a: 32'h8000_0000, b: 32'hFFFF_FFFF, tag: 6'd9,  exp: 32'h8000_0000, trivial: 1'b1, gdly: 1};
    vecs[5]  = '{op: OP_REM,  a: 32'h8000_0000, b: 32'hFFFF_FFFF, tag: 6'd10, exp: 32'd0,         trivial: 1'b1, gdly: 0};
    vecs[6]  = '{op: OP_DIVU, a: 32'd7,         b: 32'd1,         tag: 6'd11, exp: 32'd7,         trivial: 1'b1, gdly: 0};
    vecs[7]  = '{op: OP_REM,  a: 32'd10,        b: 32'd1,         tag: 6'd13, exp: 32'd0,         trivial: 1'b1, gdly: 0};
    vecs[8]  = '{op: OP_DIVU, a: 32'h8000_0000, b: 32'hFFFF_FFFF, tag: 6'd14, exp: 32'd0,         trivial: 1'b0, gdly: 0};
    vecs[9]  = '{op: OP_REM,  a: 32'hFFFF_FFF9, b: 32'd2,         tag: 6'd15, exp: 32'hFFFF_FFFF, trivial: 1'b0, gdly: 0};
    vecs[10] = '{op: OP_DIVU, a: 32'hFFFF_FFFF, b: 32'd2,         tag: 6'd63, exp: 32'h7FFF_FFFF, trivial: 1'b0, gdly: 3};
    vecs[11] = '{op: OP_REMU, a: 32'hFFFF_FFFF, b: 32'd10,        tag: 6'd0,  exp: 32'd5,         trivial: 1'b0, gdly: 0};
    vecs[12] = '{op: OP_DIVU, a: 32'd1000,      b: 32'd3,         tag: 6'd20, exp: 32'd333,       trivial: 1'b0, gdly: 0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    rs_valid  = 1'b0;
    rs_op     = OP_DIV;
    rs_src1   = '0;
    rs_src2   = '0;
    rs_tag    = '0;
    cdb_grant = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("reset_ready", 32'(rs_ready), 32'd1);
    @(negedge clk);

    // Directed table
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
             vecs[i].trivial, vecs[i].gdly);

    // Flush in WAIT (cycle 10): result dropped, ready again after div_done
    start_op(OP_DIVU, 32'd1000, 32'd3, 6'd21);
    for (int unsigned c = 1; c <= 37; c++) begin
      flush = (c == 10);
      check("drain_no_req", 32'(cdb_req), 32'd0);
      check("drain_ready", 32'(rs_ready), (c == 37) ? 32'd1 : 32'd0);
      if (c != 37) @(negedge clk);
    end
    flush = 1'b0;
    run_op(OP_DIV, 32'd9, 32'd3, 6'd22, 32'd3, 1'b0, 0);

    // Flush and grant in the same HOLD cycle
    start_op(OP_DIVU, 32'd50, 32'd5, 6'd23);
    wait_req(lat, seen);
    flush     = 1'b1;
    cdb_grant = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    check("fg_req_low", 32'(cdb_req), 32'd0);
    check("fg_ready", 32'(rs_ready), 32'd1);
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      check("fg_no_rebroadcast", 32'(cdb_req), 32'd0);
    end
    cdb_grant = 1'b0;

    // Reset in cycle 20 of a DIV
    start_op(OP_DIV, 32'd100, 32'd7, 6'd24);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", 32'(rs_ready), 32'd1);
    for (int unsigned c = 0; c < 45; c++) begin
      @(negedge clk);
      check("midrst_no_req", 32'(cdb_req), 32'd0);
    end

    // Randomized traffic against the queue model (at most one op in flight;
    // flush kills it; a granted, unflushed request retires it).
    age     = 0;
    n_bcast = 0;
    for (int unsigned c = 0; c < 3060; c++) begin
      @(negedge clk);
      if (c < 3000) begin
        rs_valid  = ($urandom_range(0, 1) == 1);
        rs_op     = OP_DIV | 5'($urandom_range(0, 3));
        rs_src1   = pick_a();
        rs_src2   = pick_b();
        rs_tag    = TAG_W'($urandom());
        cdb_grant = ($urandom_range(0, 1) == 1);
        flush     = ($urandom_range(0, 29) == 0);
      end else begin
        rs_valid  = 1'b0;
        cdb_grant = 1'b1;
        flush     = 1'b0;
      end
      #1;
      if (cdb_req) begin
        check("rand_req_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check("rand_tag", 32'(cdb_tag), 32'(q[0].tag));
          check("rand_data", cdb_data, q[0].data);
          if (cdb_grant && !flush) begin
            void'(q.pop_front());
            n_bcast++;
          end
        end
      end
      if (flush) q.delete();
      if (rs_valid && rs_ready && !flush) begin
        check("rand_one_in_flight", q.size(), 32'd0);
        e.tag  = rs_tag;
        e.data = ref_div(rs_op, rs_src1, rs_src2);
        q.push_back(e);
        age = 0;
      end
      if (q.size() != 0) begin
        age++;
        if (age > 150) begin
          check("rand_timeout", age, 32'd150);
          q.delete();
        end
      end
    end
    check("rand_drained", q.size(), 32'd0);
    check("rand_some_bcast", 32'(n_bcast > 10), 32'd1);
    check("no_start_while_busy", overlap, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue-side controller for the iterative 32-bit divider in the OoO execute stage. It accepts one DIV/DIVU/REM/REMU op at a time from the divide reservation station and launches it on the divider's start/busy/done interface. It captures the result and broadcasts it with its ROB tag on the CDB through a request/grant handshake. It also handles pipeline flushes, including the case where the divider is still running and cannot be aborted.

## Interface
- TAG_W, 6, ROB tag width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  mispredict/exception flush; kills the held op
- rs_valid  in  1  reservation station presents an op
- rs_ready  out  1  block can accept; combinational, high only in IDLE
- rs_op  in  5  5'b10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
- rs_src1 / rs_src2  in  32  dividend / divisor
- rs_tag  in  TAG_W  ROB tag
- div_start  out  1  one-cycle launch pulse to divider
- div_op_sel  out  5  op to divider
- div_rs1 / div_rs2  out  32  operands to divider
- div_busy  in  1  divider busy (monitored only)
- div_done  in  1  divider result valid, one-cycle pulse
- div_result  in  32  divider result
- cdb_req  out  1  result ready for broadcast
- cdb_grant  in  1  CDB arbiter grant, same cycle as cdb_req
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_data  out  32  broadcast result

## Operation
- States:
  - IDLE: accept when rs_valid & rs_ready & !flush; latch op, operands and tag; go to LAUNCH.
  - LAUNCH: div_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on div_done, capture div_result into cdb_data; go to HOLD.
  - HOLD: cdb_req=1. On cdb_grant, go to IDLE.
  - DRAIN: wait for div_done, discard the result, go to IDLE.
- div_op_sel, div_rs1 and div_rs2 are registered. They stay stable from LAUNCH until div_done, because the divider re-reads rs1 in its fix-up cycle for REM x/0.
- Flush behaviour by state:
  - IDLE: blocks acceptance that cycle.
  - LAUNCH or WAIT: go to DRAIN. If div_done arrives in the flush cycle, go to IDLE directly.
  - HOLD: drop the result and go to IDLE. Flush wins over a simultaneous cdb_grant; cdb_req is low the next cycle.
  - DRAIN: no effect.
- div_done seen in IDLE, LAUNCH or HOLD is ignored.
- The block holds at most one op; rs_ready is 0 outside IDLE.

## Timing
- Reset values: every registered output is 0. The state is IDLE, so rs_ready=1 as soon as rst_n deasserts.
- Accept in cycle 0 gives div_start in cycle 1.
- With the current divider (32 iterations plus fix-up plus done), div_done arrives in cycle 36 and cdb_req rises in cycle 37.
- Latency from div_done to cdb_req is exactly 1 cycle, independent of divider depth.
- cdb_req, cdb_tag and cdb_data stay stable until the grant cycle. cdb_req is low the cycle after the grant.
- The earliest next accept is the cycle after the grant. Steady-state throughput is one op per 38 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs at 0. The divider shares rst_n, so no stale done can arrive.

## Configuration
- DIV_FASTPATH_EN defined: trivial ops complete without launching the divider. IDLE goes directly to HOLD and cdb_req rises in cycle 1; div_start never pulses. Trivial cases:
  - rs_src2==0: DIV/DIVU give 32'hFFFFFFFF; REM/REMU give rs_src1.
  - Signed op with rs_src1=32'h80000000 and rs_src2=32'hFFFFFFFF: DIV gives 32'h80000000; REM gives 0.
  - rs_src2==1: DIV/DIVU give rs_src1; REM/REMU give 0.
- DIV_FASTPATH_EN undefined: every op goes through LAUNCH/WAIT. Results are identical; only latency differs.

## Structure
- Shared package riscv_div_pkg holds:
  - op codes OP_DIV/OP_DIVU/OP_REM/OP_REMU
  - the controller state encoding (IDLE, LAUNCH, WAIT, HOLD, DRAIN)
  - the TAG_W default
- The divider uses the same op-code constants from riscv_div_pkg.
- One combinational sub-module, div_fast_path, classifies trivial ops and computes their result. It is instantiated only under DIV_FASTPATH_EN.

## Test plan
- DIV -7/2, tag 5, grant held high: div_start in cycle 1, cdb_req in cycle 37 with data 32'hFFFFFFFD and tag 5; rs_ready low in cycles 1–37.
- REMU 100/7, cdb_grant low for 10 cycles after cdb_req: data 2 and the tag stay stable; accept is possible the cycle after the grant.
- DIVU 1000/3 with flush in WAIT (cycle 10): no cdb_req; rs_ready returns high the cycle after div_done; the next op, DIV 9/3, returns 3.
- Flush and cdb_grant in the same HOLD cycle: cdb_req low the next cycle, state IDLE, no double broadcast.
- rst_n pulsed low in cycle 20 of a DIV: all outputs 0 immediately, rs_ready=1 after release, no cdb_req.
- With DIV_FASTPATH_EN, DIV x/0 with x=5: cdb_req in cycle 1 with data 32'hFFFFFFFF and no div_start. Without the macro, the same data arrives in cycle 37.
